// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one memory port between icache (burst reads) and dcache (burst reads / single writes)
module mem_arbiter #(
   parameter int BURST_LEN = 4
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [31:0] i_imem_addr,
   input  logic        i_imem_ren,
   output logic        o_imem_ready,
   output logic [31:0] o_imem_rdata,
   output logic        o_imem_valid,
   input  logic [31:0] i_dmem_addr,
   input  logic        i_dmem_ren,
   input  logic        i_dmem_wen,
   input  logic [31:0] i_dmem_wdata,
   output logic        o_dmem_ready,
   output logic [31:0] o_dmem_rdata,
   output logic        o_dmem_valid,
   input  logic        i_mem_ready,
   output logic [31:0] o_mem_addr,
   output logic        o_mem_ren,
   output logic        o_mem_wen,
   output logic [31:0] o_mem_wdata,
   input  logic [31:0] i_mem_rdata,
   input  logic        i_mem_valid,
   output logic [1:0]  o_owner,
   output logic        o_stray
);
   localparam int CW = $clog2(BURST_LEN + 1);
   typedef enum logic [1:0] {IDLE, RD, WR} state_t;
   state_t state, state_n;
   logic [1:0] owner_n;
   logic last_d, last_d_n, stray_n;
   logic [CW-1:0] issue_cnt, issue_n, resp_cnt, resp_n;
   logic own_i, own_d, own_ren, full_rd, pick_d;
   assign own_i = o_owner == 2'b01;
   assign own_d = o_owner == 2'b10;
   assign own_ren = own_i ? i_imem_ren : (own_d && i_dmem_ren);
   assign full_rd = state == RD && issue_cnt == CW'(BURST_LEN);
   // last_d low means icache was served last, so dcache wins a tie
   assign pick_d = (i_dmem_ren || i_dmem_wen) && (!i_imem_ren || !last_d);
   assign o_mem_ren = state == RD && own_ren && !full_rd;
   assign o_mem_wen = state == WR && own_d && i_dmem_wen;
   assign o_mem_addr = own_i ? i_imem_addr : own_d ? i_dmem_addr : '0;
   assign o_mem_wdata = own_d ? i_dmem_wdata : '0;
   assign o_imem_ready = own_i && i_mem_ready && !full_rd;
   assign o_dmem_ready = own_d && i_mem_ready && !full_rd;
   assign o_imem_valid = own_i && state == RD && i_mem_valid;
   assign o_dmem_valid = own_d && state == RD && i_mem_valid;
   assign o_imem_rdata = own_i ? i_mem_rdata : '0;
   assign o_dmem_rdata = own_d ? i_mem_rdata : '0;
   always_comb begin
      state_n = state;
      owner_n = o_owner;
      last_d_n = last_d;
      issue_n = issue_cnt;
      resp_n = resp_cnt;
      stray_n = o_stray || (i_mem_valid && state != RD);
      case (state)
         IDLE: begin
            if (pick_d) begin
               state_n = i_dmem_wen ? WR : RD;
               owner_n = 2'b10;
            end else if (i_imem_ren) begin
               state_n = RD;
               owner_n = 2'b01;
            end
         end
         RD: begin
            if (o_mem_ren && i_mem_ready) issue_n = issue_cnt + 1'b1;
            if (i_mem_valid) resp_n = resp_cnt + 1'b1;
            if (i_mem_valid && resp_cnt == CW'(BURST_LEN - 1)) begin
               state_n = IDLE;
               owner_n = 2'b00;
               issue_n = '0;
               resp_n = '0;
               last_d_n = own_d;
            end
         end
         WR: begin
            if (o_mem_wen && i_mem_ready) begin
               state_n = IDLE;
               owner_n = 2'b00;
               last_d_n = 1'b1;
            end
         end
         default: begin
            state_n = IDLE;
            owner_n = 2'b00;
         end
      endcase
   end
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= IDLE;
         o_owner <= 2'b00;
         last_d <= 1'b0;
         issue_cnt <= '0;
         resp_cnt <= '0;
         o_stray <= 1'b0;
      end else begin
         state <= state_n;
         o_owner <= owner_n;
         last_d <= last_d_n;
         issue_cnt <= issue_n;
         resp_cnt <= resp_n;
         o_stray <= stray_n;
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenario tests for mem_arbiter
module tb_mem_arbiter;
   logic i_clk, i_rst_n;
   logic [31:0] i_imem_addr, o_imem_rdata, i_dmem_addr, i_dmem_wdata, o_dmem_rdata;
   logic [31:0] o_mem_addr, o_mem_wdata, i_mem_rdata;
   logic i_imem_ren, o_imem_ready, o_imem_valid;
   logic i_dmem_ren, i_dmem_wen, o_dmem_ready, o_dmem_valid;
   logic i_mem_ready, o_mem_ren, o_mem_wen, i_mem_valid, o_stray;
   logic [1:0] o_owner;
   int checks = 0;
   int errors = 0;
   mem_arbiter #(.BURST_LEN(4)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .i_imem_addr(i_imem_addr), .i_imem_ren(i_imem_ren), .o_imem_ready(o_imem_ready),
      .o_imem_rdata(o_imem_rdata), .o_imem_valid(o_imem_valid),
      .i_dmem_addr(i_dmem_addr), .i_dmem_ren(i_dmem_ren), .i_dmem_wen(i_dmem_wen),
      .i_dmem_wdata(i_dmem_wdata), .o_dmem_ready(o_dmem_ready), .o_dmem_rdata(o_dmem_rdata),
      .o_dmem_valid(o_dmem_valid),
      .i_mem_ready(i_mem_ready), .o_mem_addr(o_mem_addr), .o_mem_ren(o_mem_ren),
      .o_mem_wen(o_mem_wen), .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata),
      .i_mem_valid(i_mem_valid), .o_owner(o_owner), .o_stray(o_stray)
   );
   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;
   task automatic tick;
      @(posedge i_clk);
      #1;
   endtask
   task automatic clr_inputs;
      i_imem_addr = '0; i_imem_ren = 0; i_dmem_addr = '0; i_dmem_ren = 0; i_dmem_wen = 0;
      i_dmem_wdata = '0; i_mem_ready = 0; i_mem_rdata = '0; i_mem_valid = 0;
   endtask
   task automatic do_reset;
      clr_inputs();
      i_rst_n = 0;
      tick();
      tick();
      i_rst_n = 1;
   endtask
   // drives four back-to-back responses while already granted to own
   task automatic run_burst(input logic [1:0] own);
      for (int k = 0; k < 4; k++) begin
         i_mem_valid = 1; i_mem_rdata = 32'hC0DE_0000 + k;
         #1;
         checks++; if (o_owner !== own) begin errors++; $display("FAIL burst_owner k=%0d got %b exp %b", k, o_owner, own); end
         checks++; if ({o_imem_valid, o_dmem_valid} !== {own == 2'b01, own == 2'b10}) begin errors++; $display("FAIL burst_valid k=%0d got %b%b", k, o_imem_valid, o_dmem_valid); end
         checks++; if ((own == 2'b01 ? o_imem_rdata : o_dmem_rdata) !== 32'hC0DE_0000 + k) begin errors++; $display("FAIL burst_rdata k=%0d got %h", k, own == 2'b01 ? o_imem_rdata : o_dmem_rdata); end
         tick();
      end
      i_mem_valid = 0;
      #1;
      checks++; if (o_owner !== 2'b00) begin errors++; $display("FAIL burst_release got %b exp 00", o_owner); end
   endtask
   task automatic test_reset;
      clr_inputs();
      i_rst_n = 0;
      i_imem_ren = 1; i_dmem_wen = 1; i_mem_ready = 1; i_mem_valid = 1; i_imem_addr = 32'h55;
      tick();
      tick();
      checks++; if (o_owner !== 2'b00) begin errors++; $display("FAIL reset_owner got %b exp 00", o_owner); end
      checks++; if ({o_mem_ren, o_mem_wen, o_imem_ready, o_dmem_ready, o_imem_valid, o_dmem_valid, o_stray} !== 7'b0) begin errors++; $display("FAIL reset_ctrl got %b exp 0", {o_mem_ren, o_mem_wen, o_imem_ready, o_dmem_ready, o_imem_valid, o_dmem_valid, o_stray}); end
      checks++; if (o_mem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", o_mem_addr); end
      clr_inputs();
      i_rst_n = 1;
   endtask
   task automatic test_icache_burst;
      logic [31:0] data [4];
      data[0] = 32'hAAAA_0001; data[1] = 32'hBBBB_0002; data[2] = 32'hCCCC_0003; data[3] = 32'hDDDD_0004;
      do_reset();
      i_imem_ren = 1; i_imem_addr = 32'h100; i_mem_ready = 1;
      #1;
      checks++; if ({o_owner, o_mem_ren} !== 3'b000) begin errors++; $display("FAIL icache_idle got %b exp 000", {o_owner, o_mem_ren}); end
      tick();
      for (int c = 0; c < 5; c++) begin
         i_imem_ren = c < 4;
         i_mem_valid = c >= 1;
         i_mem_rdata = c >= 1 ? data[c-1] : 32'h0;
         #1;
         checks++; if (o_owner !== 2'b01) begin errors++; $display("FAIL icache_owner c=%0d got %b exp 01", c, o_owner); end
         checks++; if (o_mem_ren !== (c < 4) || o_mem_addr !== 32'h100) begin errors++; $display("FAIL icache_ren c=%0d got %b %h", c, o_mem_ren, o_mem_addr); end
         checks++; if (o_imem_valid !== (c >= 1) || o_dmem_valid !== 1'b0) begin errors++; $display("FAIL icache_valid c=%0d got %b%b", c, o_imem_valid, o_dmem_valid); end
         if (c >= 1) begin
            checks++; if (o_imem_rdata !== data[c-1]) begin errors++; $display("FAIL icache_rdata c=%0d got %h exp %h", c, o_imem_rdata, data[c-1]); end
         end
         tick();
      end
      i_mem_valid = 0;
      #1;
      checks++; if ({o_owner, o_mem_ren, o_stray} !== 4'b0) begin errors++; $display("FAIL icache_done got %b exp 0000", {o_owner, o_mem_ren, o_stray}); end
   endtask
   task automatic test_tie;
      do_reset();
      i_imem_ren = 1; i_dmem_ren = 1; i_mem_ready = 1;
      tick();
      #1;
      checks++; if ({o_imem_ready, o_dmem_ready} !== 2'b01) begin errors++; $display("FAIL tie_ready got %b exp 01", {o_imem_ready, o_dmem_ready}); end
      run_burst(2'b10);
      tick();
      run_burst(2'b01);
      tick();
      i_imem_ren = 0; i_dmem_ren = 0;
      run_burst(2'b10);
   endtask
   task automatic test_write;
      do_reset();
      i_imem_ren = 1; i_dmem_wen = 1; i_dmem_ren = 1; i_dmem_addr = 32'h40; i_dmem_wdata = 32'hDEADBEEF;
      #1;
      checks++; if (o_mem_wen !== 1'b0) begin errors++; $display("FAIL wr_idle got %b exp 0", o_mem_wen); end
      tick();
      for (int c = 0; c < 4; c++) begin
         i_mem_ready = c == 3;
         #1;
         checks++; if ({o_owner, o_mem_wen, o_mem_ren} !== 4'b1010) begin errors++; $display("FAIL wr_ctrl c=%0d got %b exp 1010", c, {o_owner, o_mem_wen, o_mem_ren}); end
         checks++; if (o_mem_wdata !== 32'hDEADBEEF || o_mem_addr !== 32'h40) begin errors++; $display("FAIL wr_data c=%0d got %h %h", c, o_mem_addr, o_mem_wdata); end
         checks++; if ({o_imem_ready, o_dmem_ready} !== {1'b0, c == 3}) begin errors++; $display("FAIL wr_ready c=%0d got %b", c, {o_imem_ready, o_dmem_ready}); end
         tick();
      end
      i_dmem_wen = 0; i_dmem_ren = 0;
      #1;
      checks++; if ({o_owner, o_mem_wen, o_imem_ready} !== 4'b0) begin errors++; $display("FAIL wr_done got %b exp 0000", {o_owner, o_mem_wen, o_imem_ready}); end
      tick();
      checks++; if (o_owner !== 2'b01) begin errors++; $display("FAIL wr_next_grant got %b exp 01", o_owner); end
   endtask
   task automatic test_ren_mask;
      int pulses = 0;
      do_reset();
      i_imem_ren = 1; i_mem_ready = 1;
      tick();
      for (int c = 0; c < 6; c++) begin
         #1;
         pulses += int'(o_mem_ren);
         if (c == 5) begin
            checks++; if (o_imem_ready !== 1'b0) begin errors++; $display("FAIL mask_ready got %b exp 0", o_imem_ready); end
         end
         tick();
      end
      checks++; if (pulses !== 4) begin errors++; $display("FAIL mask_count got %0d exp 4", pulses); end
      run_burst(2'b01);
   endtask
   task automatic test_stray;
      do_reset();
      #1;
      checks++; if (o_stray !== 1'b0) begin errors++; $display("FAIL stray_init got %b exp 0", o_stray); end
      i_mem_valid = 1;
      #1;
      checks++; if ({o_imem_valid, o_dmem_valid} !== 2'b00) begin errors++; $display("FAIL stray_drop got %b exp 00", {o_imem_valid, o_dmem_valid}); end
      tick();
      i_mem_valid = 0;
      #1;
      checks++; if (o_stray !== 1'b1) begin errors++; $display("FAIL stray_set got %b exp 1", o_stray); end
      tick();
      tick();
      checks++; if (o_stray !== 1'b1) begin errors++; $display("FAIL stray_hold got %b exp 1", o_stray); end
   endtask
   task automatic test_reset_mid;
      do_reset();
      i_imem_ren = 1; i_imem_addr = 32'h200; i_mem_ready = 1;
      tick();
      i_mem_valid = 1;
      tick();
      tick();
      #1;
      checks++; if (o_imem_valid !== 1'b1) begin errors++; $display("FAIL mid_pre got %b exp 1", o_imem_valid); end
      i_rst_n = 0;
      #1;
      checks++; if ({o_owner, o_mem_ren, o_imem_ready, o_imem_valid} !== 5'b0 || o_mem_addr !== 32'h0) begin errors++; $display("FAIL mid_reset got %b %h", {o_owner, o_mem_ren, o_imem_ready, o_imem_valid}, o_mem_addr); end
      i_mem_valid = 0; i_imem_ren = 0;
      tick();
      i_rst_n = 1;
      #1;
      checks++; if (o_stray !== 1'b0) begin errors++; $display("FAIL mid_stray0 got %b exp 0", o_stray); end
      i_mem_valid = 1;
      #1;
      checks++; if (o_imem_valid !== 1'b0) begin errors++; $display("FAIL mid_late_valid got %b exp 0", o_imem_valid); end
      tick();
      i_mem_valid = 0;
      #1;
      checks++; if (o_stray !== 1'b1) begin errors++; $display("FAIL mid_stray1 got %b exp 1", o_stray); end
   endtask
   initial begin
      test_reset();
      test_icache_burst();
      test_tie();
      test_write();
      test_ren_mask();
      test_stray();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter BURST_LEN, default 4, giving the number of read responses per read grant (one cache line).
REQ-002 SHALL have ports: i_clk  in  1  sole clock, rising edge.
REQ-003 SHALL have ports: i_rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have icache-side ports: i_imem_addr in 32, i_imem_ren in 1, o_imem_ready out 1, o_imem_rdata out 32, o_imem_valid out 1.
REQ-005 SHALL have dcache-side ports: i_dmem_addr in 32, i_dmem_ren in 1, i_dmem_wen in 1, i_dmem_wdata in 32, o_dmem_ready out 1, o_dmem_rdata out 32, o_dmem_valid out 1.
REQ-006 SHALL have memory-side ports: i_mem_ready in 1, o_mem_addr out 32, o_mem_ren out 1, o_mem_wen out 1, o_mem_wdata out 32, i_mem_rdata in 32, i_mem_valid in 1.
REQ-007 SHALL have status ports: o_owner out 2 (00 none, 01 icache, 10 dcache); o_stray out 1 (sticky unexpected-response flag).

Function
REQ-008 SHALL implement states IDLE, RD, WR; o_owner reflects the registered grant owner.
REQ-009 IDLE: a port requests if ren, or wen for dcache; no request is forwarded to memory while in IDLE.
REQ-010 IDLE, single requester: grant it at the next edge; go to WR if dcache wen, else RD.
REQ-011 IDLE, both requesting: grant the port not granted last (round-robin); last_grant resets to icache, so dcache wins the first tie.
REQ-012 If dcache asserts ren and wen together, wen SHALL win and ren SHALL be ignored.
REQ-013 While granted, o_mem_addr/ren/wen/wdata SHALL equal the owner's inputs combinationally; non-owner fields SHALL be driven 0.
REQ-014 Memory-side outputs SHALL be 0 in IDLE.
REQ-015 o_X_ready SHALL equal i_mem_ready only for the owner; it is 0 for the other port and in IDLE.
REQ-016 RD: issue counter increments on each owner ren with i_mem_ready; at BURST_LEN, further ren SHALL be masked from memory and o_X_ready forced 0.
REQ-017 RD: response counter increments on each i_mem_valid; responses are in order.
REQ-018 o_X_valid SHALL equal i_mem_valid for the owner only; o_X_rdata SHALL equal i_mem_rdata for the owner and 0 otherwise.
REQ-019 RD SHALL return to IDLE at the edge on which the BURST_LEN-th response arrives; both counters clear; last_grant becomes the owner.
REQ-020 WR SHALL return to IDLE at the edge on which wen with i_mem_ready is accepted; last_grant becomes dcache.
REQ-021 WR: an owner ren SHALL be masked from memory.
REQ-022 i_mem_valid in IDLE or WR, or beyond BURST_LEN in RD, SHALL be dropped (no o_X_valid) and SHALL set o_stray until reset.
REQ-023 Counters SHALL be clog2(BURST_LEN+1) bits wide and SHALL never wrap.
REQ-024 A deasserted owner request SHALL NOT release the grant; release occurs only per REQ-019/REQ-020.
REQ-025 Zero grant latency is excluded: a grant always costs exactly one IDLE cycle.

Reset
REQ-026 Asserting i_rst_n low SHALL immediately force IDLE, counters 0, last_grant=icache, o_stray=0, and o_owner=00.
REQ-027 During reset, all outputs SHALL be 0 and no memory request SHALL be issued.
REQ-028 A reset mid-burst SHALL abandon the burst; responses arriving after reset release SHALL count as stray.

Verification
REQ-029 icache ren addr 0x100, mem ready, 4 valids (data A..D) -> o_owner=01 one cycle later; o_imem_valid x4 with A..D; IDLE after the 4th; o_dmem_valid never set.
REQ-030 Both request in the same IDLE cycle after reset -> dcache granted first; icache granted on the next IDLE; a further tie goes to dcache.
REQ-031 dcache wen addr 0x40 data 0xDEADBEEF, i_mem_ready low 3 cycles then high -> o_mem_wen=1 with 0xDEADBEEF for 4 cycles; IDLE the next cycle; icache ready stays 0 throughout.
REQ-032 Owner asserts ren 6 times, ready high -> exactly 4 o_mem_ren pulses.
REQ-033 i_mem_valid pulsed in IDLE -> o_stray=1 and held; no o_X_valid.
REQ-034 i_rst_n low after 2 of 4 responses -> o_owner=00 and outputs 0 immediately; a 3rd response after release sets o_stray.
